// File: rtl/rfphoenix_mem_req_queue_pkg.sv
// -----------------------------------------------------------------------------
// rfphoenix_mem_req_queue_pkg
//   Shared types and sizing constants for the memory request queue.
//   MemoryArg_t : one request from the memory-issue stage to the memory unit.
//   NTHREADS    : number of hardware threads (rollback / bitmap width).
//   MEMQ_DEP    : default request queue depth used at the top level.
// -----------------------------------------------------------------------------
package rfphoenix_mem_req_queue_pkg;

   localparam int unsigned NTHREADS = 4;
   localparam int unsigned THREAD_W = 2;
   localparam int unsigned NTARGETS = 128;
   localparam int unsigned MEMQ_DEP = 16;

   typedef enum logic [1:0] {
      MemLoad  = 2'd0,
      MemStore = 2'd1,
      MemAmo   = 2'd2,
      MemFence = 2'd3
   } mem_op_e;

   typedef struct packed {
      logic [THREAD_W-1:0] thread;
      logic [6:0]          tgt;
      mem_op_e             op;
      logic [31:0]         addr;
      logic [31:0]         data;
   } MemoryArg_t;

   // True when the flush vector hits the given thread.
   function automatic logic thread_flushed(input logic [NTHREADS-1:0] rb,
                                           input logic [THREAD_W-1:0] thr);
      return rb[thr];
   endfunction

endpackage

// File: rtl/rfphoenix_mem_req_queue.sv
// -----------------------------------------------------------------------------
// rfphoenix_mem_req_queue
//   In-order request queue between the memory-issue stage and the memory unit.
//   Requests are stored in a circular buffer and presented one at a time from
//   a registered output stage using a valid/ack handshake. A per-thread
//   rollback strobe invalidates that thread's queued requests in place; stale
//   slots are skipped when they reach the head.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   wr, di            push request (dropped when full)
//   full, empty, cnt  storage status (cnt excludes the output register)
//   req_v, req_o      registered head request toward the memory unit
//   req_ack           memory unit accepts req_o this cycle
//   rollback          per-thread flush strobe
//   pending_bitmaps   [thread][tgt] set while a request is queued or unsent
// -----------------------------------------------------------------------------
module rfphoenix_mem_req_queue
   import rfphoenix_mem_req_queue_pkg::*;
#(
   parameter int unsigned DEP = MEMQ_DEP
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                wr,
   input  MemoryArg_t                          di,
   output logic                                full,
   output logic                                empty,
   output logic [$clog2(DEP):0]                cnt,
   output logic                                req_v,
   output MemoryArg_t                          req_o,
   input  logic                                req_ack,
   input  logic [NTHREADS-1:0]                 rollback,
   output logic [NTHREADS-1:0][NTARGETS-1:0]   pending_bitmaps
);

   localparam int unsigned AW = $clog2(DEP);
   localparam int unsigned CW = AW + 1;

   logic [AW-1:0]                        wptr_q, wptr_d;
   logic [AW-1:0]                        rptr_q, rptr_d;
   logic [CW-1:0]                        count_q, count_d;
   logic [DEP-1:0]                       vld_q, vld_d;
   logic                                 req_v_q, req_v_d;
   MemoryArg_t                           req_o_q, req_o_d;
   logic [NTHREADS-1:0][NTARGETS-1:0]    bm_q, bm_d;

   // Payload storage is not reset; vld_q alone decides whether a slot is live.
   MemoryArg_t                           mem_q [DEP];

   logic       push;
   logic       xfer;
   logic       load;
   logic       push_ok;
   logic       head_ok;
   MemoryArg_t head;

   // Status decodes straight from flops.
   assign full            = (count_q == CW'(DEP));
   assign empty           = (count_q == '0) && !req_v_q;
   assign cnt             = count_q;
   assign req_v           = req_v_q;
   assign req_o           = req_o_q;
   assign pending_bitmaps = bm_q;

   assign head    = mem_q[rptr_q];
   assign push    = wr && !full;
   assign xfer    = req_v_q && req_ack;
   // Output register is free when empty or being accepted this cycle.
   assign load    = (!req_v_q || req_ack) && (count_q != '0);
   assign push_ok = !thread_flushed(rollback, di.thread);
   assign head_ok = vld_q[rptr_q] && !thread_flushed(rollback, head.thread);

   // Pointers and occupancy.
   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (push) begin
         wptr_d = wptr_q + AW'(1);
      end
      if (load) begin
         rptr_d = rptr_q + AW'(1);
      end
      if (push && !load) begin
         count_d = count_q + CW'(1);
      end else if (load && !push) begin
         count_d = count_q - CW'(1);
      end
   end

   // Slot valid bits. Push and load never address the same slot: a push needs
   // count<DEP and a load needs count>0, so wptr==rptr cannot hold for both.
   always_comb begin
      vld_d = vld_q;
      for (int i = 0; i < int'(DEP); i++) begin
         if (thread_flushed(rollback, mem_q[i].thread)) begin
            vld_d[i] = 1'b0;
         end
      end
      if (load) begin
         vld_d[rptr_q] = 1'b0;
      end
      if (push) begin
         vld_d[wptr_q] = push_ok;
      end
   end

   // Output register. A completing transfer is never undone by rollback; the
   // load branch covers transfer-with-refill, the xfer branch transfer-to-idle.
   always_comb begin
      req_v_d = req_v_q;
      req_o_d = req_o_q;
      if (load) begin
         req_v_d = head_ok;
         if (vld_q[rptr_q]) begin
            req_o_d = head;
         end
      end else if (xfer) begin
         req_v_d = 1'b0;
      end else if (req_v_q && thread_flushed(rollback, req_o_q.thread)) begin
         req_v_d = 1'b0;
      end
   end

   // Pending bitmaps: clear on transfer, set on push (set wins), rollback last.
   always_comb begin
      bm_d = bm_q;
      if (xfer) begin
         bm_d[req_o_q.thread][req_o_q.tgt] = 1'b0;
      end
      if (push && push_ok) begin
         bm_d[di.thread][di.tgt] = 1'b1;
      end
      for (int t = 0; t < int'(NTHREADS); t++) begin
         if (rollback[t]) begin
            bm_d[t] = '0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         vld_q   <= '0;
         req_v_q <= 1'b0;
         req_o_q <= '0;
         bm_q    <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         vld_q   <= vld_d;
         req_v_q <= req_v_d;
         req_o_q <= req_o_d;
         bm_q    <= bm_d;
      end
   end

   // Distributed-RAM style write port.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wptr_q] <= di;
      end
   end

endmodule
